// File: rtl/orientation_hist_controller.sv
// Orientation histogram controller: accumulates 36 saturating magnitude bins per keypoint,
// hands them to a maximum detector, and returns the winning bin and its peak value.
module orientation_hist_controller #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic         iclk,
    input  logic         ireset,
    input  logic         isample_valid,
    output logic         osample_ready,
    input  logic [5:0]   isample_bin,
    input  logic [15:0]  isample_mag,
    input  logic         isample_last,
    output logic [575:0] ohist_bins,
    output logic         odetect_en,
    input  logic         idetect_en,
    input  logic [5:0]   idetect_orient,
    output logic         oresult_valid,
    input  logic         iresult_ready,
    output logic [5:0]   oresult_orient,
    output logic [15:0]  oresult_peak,
    output logic         oerr_bin,
    output logic         oerr_timeout,
    output logic         obusy
);

    localparam int unsigned NumBins = 36;
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {StAccum, StIssue, StWait, StResult} state_e;

    state_e      state_q;
    logic [15:0] bins_q [NumBins];
    logic [15:0] cnt_q;

    logic        bin_ok;
    logic        det_ok;
    logic [15:0] cur_bin;
    logic [15:0] det_bin;
    logic [16:0] sum;

    always_comb begin
        bin_ok  = isample_bin < 6'd36;
        det_ok  = idetect_orient < 6'd36;
        cur_bin = bin_ok ? bins_q[isample_bin] : 16'h0000;
        det_bin = det_ok ? bins_q[idetect_orient] : 16'h0000;
        sum     = {1'b0, cur_bin} + {1'b0, isample_mag};
    end

    always_comb begin
        ohist_bins = '0;
        for (int i = 0; i < NumBins; i++) begin
            ohist_bins[16*i +: 16] = bins_q[i];
        end
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            state_q        <= StAccum;
            for (int i = 0; i < NumBins; i++) bins_q[i] <= 16'h0000;
            cnt_q          <= 16'h0000;
            odetect_en     <= 1'b0;
            oresult_valid  <= 1'b0;
            osample_ready  <= 1'b1;
            obusy          <= 1'b0;
            oresult_orient <= 6'h00;
            oresult_peak   <= 16'h0000;
            oerr_bin       <= 1'b0;
            oerr_timeout   <= 1'b0;
        end else begin
            unique case (state_q)
                StAccum: begin
                    if (isample_valid) begin
                        if (bin_ok) begin
                            bins_q[isample_bin] <= sum[16] ? 16'hFFFF : sum[15:0];
                        end else begin
                            oerr_bin <= 1'b1;
                        end
                        if (isample_last) begin
                            state_q       <= StIssue;
                            odetect_en    <= 1'b1;
                            osample_ready <= 1'b0;
                            obusy         <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    state_q    <= StWait;
                    odetect_en <= 1'b0;
                    cnt_q      <= 16'h0000;
                end
                StWait: begin
                    // A strobe on the final allowed cycle still counts as a real answer.
                    if (idetect_en) begin
                        oresult_orient <= idetect_orient;
                        oresult_peak   <= det_bin;
                        oresult_valid  <= 1'b1;
                        state_q        <= StResult;
                    end else if (cnt_q == TimeoutLast) begin
                        oresult_orient <= 6'h3F;
                        oresult_peak   <= 16'h0000;
                        oerr_timeout   <= 1'b1;
                        oresult_valid  <= 1'b1;
                        state_q        <= StResult;
                    end else begin
                        cnt_q <= cnt_q + 16'h0001;
                    end
                end
                StResult: begin
                    if (iresult_ready) begin
                        for (int i = 0; i < NumBins; i++) bins_q[i] <= 16'h0000;
                        oresult_valid <= 1'b0;
                        osample_ready <= 1'b1;
                        obusy         <= 1'b0;
                        state_q       <= StAccum;
                    end
                end
                default: state_q <= StAccum;
            endcase
        end
    end

endmodule

// File: tb/tb_orientation_hist_controller.sv
// Randomised bench for orientation_hist_controller against a bin-array reference model.
module tb_orientation_hist_controller;

    localparam int unsigned TIMEOUT = 15;

    logic         iclk = 1'b0;
    logic         ireset = 1'b0;
    logic         isample_valid = 1'b0;
    logic         osample_ready;
    logic [5:0]   isample_bin = '0;
    logic [15:0]  isample_mag = '0;
    logic         isample_last = 1'b0;
    logic [575:0] ohist_bins;
    logic         odetect_en;
    logic         idetect_en = 1'b0;
    logic [5:0]   idetect_orient = '0;
    logic         oresult_valid;
    logic         iresult_ready = 1'b0;
    logic [5:0]   oresult_orient;
    logic [15:0]  oresult_peak;
    logic         oerr_bin;
    logic         oerr_timeout;
    logic         obusy;

    orientation_hist_controller #(.TIMEOUT(TIMEOUT)) dut (
        .iclk           (iclk),
        .ireset         (ireset),
        .isample_valid  (isample_valid),
        .osample_ready  (osample_ready),
        .isample_bin    (isample_bin),
        .isample_mag    (isample_mag),
        .isample_last   (isample_last),
        .ohist_bins     (ohist_bins),
        .odetect_en     (odetect_en),
        .idetect_en     (idetect_en),
        .idetect_orient (idetect_orient),
        .oresult_valid  (oresult_valid),
        .iresult_ready  (iresult_ready),
        .oresult_orient (oresult_orient),
        .oresult_peak   (oresult_peak),
        .oerr_bin       (oerr_bin),
        .oerr_timeout   (oerr_timeout),
        .obusy          (obusy)
    );

    always #5 iclk = ~iclk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [575:0] obs, input logic [575:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [5:0]  bin;
        logic [15:0] mag;
    } samp_t;

    samp_t       sq[$];
    int unsigned m_bins[36];
    bit          m_err_bin;
    bit          m_err_to;

    function automatic logic [575:0] model_vec();
        logic [575:0] v;
        v = '0;
        for (int i = 0; i < 36; i++) v[16*i +: 16] = 16'(m_bins[i]);
        return v;
    endfunction

    task automatic model_clear(input bit flags);
        for (int i = 0; i < 36; i++) m_bins[i] = 0;
        if (flags) begin
            m_err_bin = 0;
            m_err_to  = 0;
        end
    endtask

    // Present every queued sample; stray detector strobes in ACCUM must be ignored.
    task automatic feed();
        for (int i = 0; i < sq.size(); i++) begin
            isample_valid  = 1'b1;
            isample_bin    = sq[i].bin;
            isample_mag    = sq[i].mag;
            isample_last   = (i == sq.size() - 1);
            idetect_en     = 1'($urandom_range(0, 1));
            idetect_orient = 6'($urandom_range(0, 63));
            check("sample_ready", 576'(osample_ready), 576'(1));
            if (sq[i].bin < 36) begin
                int unsigned s;
                s = m_bins[sq[i].bin] + sq[i].mag;
                m_bins[sq[i].bin] = (s > 65535) ? 65535 : s;
            end else begin
                m_err_bin = 1;
            end
            @(posedge iclk); #1;
            check("err_bin", 576'(oerr_bin), 576'(m_err_bin));
        end
        isample_valid = 1'b0;
        isample_last  = 1'b0;
        idetect_en    = 1'b0;
    endtask

    // lat = cycles from issue pulse to detector strobe; 0 means the detector never answers.
    task automatic run_kp(input int lat, input logic [5:0] orient, input int hold);
        int          exp_k;
        int          got_k;
        bit          extra;
        bit          stable;
        logic [5:0]  e_orient;
        logic [15:0] e_peak;
        feed();
        check("issue_pulse", 576'(odetect_en), 576'(1));
        check("issue_busy", 576'(obusy), 576'(1));
        check("issue_ready", 576'(osample_ready), 576'(0));
        check("issue_hist", ohist_bins, model_vec());
        exp_k = ((lat > 0) ? lat : TIMEOUT) + 1;
        got_k = 0;
        extra = 0;
        for (int k = 1; k <= TIMEOUT + 3 && got_k == 0; k++) begin
            @(posedge iclk); #1;
            if (odetect_en) extra = 1;
            if (oresult_valid) got_k = k;
            else begin
                idetect_en     = (k == lat);
                idetect_orient = orient;
            end
        end
        idetect_en = 1'b0;
        check("result_latency", 576'(got_k), 576'(exp_k));
        check("pulse_once", 576'(extra), 576'(0));
        if (lat > 0) begin
            e_orient = orient;
            e_peak   = (orient < 36) ? 16'(m_bins[orient]) : 16'h0000;
        end else begin
            e_orient = 6'h3F;
            e_peak   = 16'h0000;
            m_err_to = 1;
        end
        check("orient", 576'(oresult_orient), 576'(e_orient));
        check("peak", 576'(oresult_peak), 576'(e_peak));
        check("err_timeout", 576'(oerr_timeout), 576'(m_err_to));
        check("result_hist", ohist_bins, model_vec());
        stable = 1;
        for (int h = 0; h < hold; h++) begin
            idetect_en     = 1'($urandom_range(0, 1));
            idetect_orient = 6'($urandom_range(0, 63));
            @(posedge iclk); #1;
            if (!oresult_valid || oresult_orient !== e_orient || oresult_peak !== e_peak ||
                osample_ready || ohist_bins !== model_vec()) stable = 0;
        end
        idetect_en = 1'b0;
        check("hold_stable", 576'(stable), 576'(1));
        iresult_ready = 1'b1;
        @(posedge iclk); #1;
        iresult_ready = 1'b0;
        model_clear(0);
        check("post_valid", 576'(oresult_valid), 576'(0));
        check("post_ready", 576'(osample_ready), 576'(1));
        check("post_busy", 576'(obusy), 576'(0));
        check("post_hist", ohist_bins, model_vec());
        sq.delete();
    endtask

    initial begin
        int          n;
        int          lat;
        logic [5:0]  orient;
        samp_t       s;
        bit          seen;
        model_clear(1);
        #12;
        check("rst_ready", 576'(osample_ready), 576'(1));
        check("rst_busy", 576'(obusy), 576'(0));
        check("rst_hist", ohist_bins, 576'(0));
        check("rst_payload", 576'({oresult_valid, odetect_en, oresult_orient, oresult_peak}),
              576'(0));
        check("rst_flags", 576'({oerr_bin, oerr_timeout}), 576'(0));
        @(negedge iclk);
        ireset = 1'b1;
        @(posedge iclk); #1;

        // Nominal keypoint, latency 7, winner bin 3.
        sq.push_back('{bin: 6'd3, mag: 16'd100});
        sq.push_back('{bin: 6'd3, mag: 16'd50});
        sq.push_back('{bin: 6'd10, mag: 16'd120});
        run_kp(7, 6'd3, 0);
        check("ex_peak150", 576'(oresult_peak), 576'(150));
        // Saturation.
        sq.push_back('{bin: 6'd5, mag: 16'hFFF0});
        sq.push_back('{bin: 6'd5, mag: 16'h0100});
        run_kp(4, 6'd5, 1);
        check("ex_peak_sat", 576'(oresult_peak), 576'(16'hFFFF));
        // Invalid bin, then latency boundaries and timeout with a long hold.
        sq.push_back('{bin: 6'd40, mag: 16'd9});
        sq.push_back('{bin: 6'd0, mag: 16'd7});
        run_kp(1, 6'd0, 2);
        sq.push_back('{bin: 6'd35, mag: 16'd3});
        run_kp(TIMEOUT, 6'd35, 0);
        sq.push_back('{bin: 6'd2, mag: 16'd11});
        run_kp(0, 6'd2, 20);
        sq.push_back('{bin: 6'd7, mag: 16'd5});
        run_kp(3, 6'd50, 1);

        for (int t = 0; t < 25; t++) begin
            n = $urandom_range(1, 8);
            for (int j = 0; j < n; j++) begin
                s.bin = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(36, 63))
                                                    : 6'($urandom_range(0, 35));
                s.mag = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(60000, 65535))
                                                    : 16'($urandom_range(0, 65535));
                sq.push_back(s);
            end
            lat    = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TIMEOUT);
            orient = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(36, 63))
                                                 : sq[0].bin;
            run_kp(lat, orient, $urandom_range(0, 5));
        end

        // Reset in the middle of WAIT discards the keypoint; late strobes are ignored.
        sq.push_back('{bin: 6'd4, mag: 16'd77});
        feed();
        repeat (3) @(posedge iclk);
        #2;
        ireset = 1'b0;
        #1;
        check("async_busy", 576'(obusy), 576'(0));
        @(negedge iclk);
        ireset = 1'b1;
        model_clear(1);
        sq.delete();
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            idetect_en     = 1'b1;
            idetect_orient = 6'd4;
            @(posedge iclk); #1;
            if (oresult_valid || odetect_en) seen = 1;
        end
        idetect_en = 1'b0;
        check("stale_ignored", 576'(seen), 576'(0));
        check("rr_ready", 576'(osample_ready), 576'(1));
        check("rr_hist", ohist_bins, model_vec());
        check("rr_payload", 576'({oresult_orient, oresult_peak}), 576'(0));
        check("rr_flags", 576'({oerr_bin, oerr_timeout, obusy}), 576'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/orientation_hist_controller.md
ORIENTATION_HIST_CONTROLLER -- requirements
Module: orientation_hist_controller

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning max cycles waited for detector response after issue.
REQ-002 SHALL have ports: iclk  in  1  clock; ireset  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: isample_valid  in  1  sample offered; osample_ready  out  1  sample accepted when both high.
REQ-004 SHALL have ports: isample_bin  in  6  bin index 0..35; isample_mag  in  16  unsigned weighted magnitude; isample_last  in  1  final sample of keypoint.
REQ-005 SHALL have port ohist_bins  out  576  36 x 16-bit bins, bin n at [16n+15:16n], wired to maximum-detector bin inputs.
REQ-006 SHALL have ports: odetect_en  out  1  one-cycle issue pulse to detector; idetect_en  in  1  detector result strobe; idetect_orient  in  6  detector winning bin.
REQ-007 SHALL have ports: oresult_valid  out  1; iresult_ready  in  1; oresult_orient  out  6; oresult_peak  out  16 -- result handshake and payload.
REQ-008 SHALL have ports: oerr_bin  out  1  sticky invalid-bin flag; oerr_timeout  out  1  sticky detector-timeout flag; obusy  out  1  high in any state except ACCUM.

Function
REQ-009 SHALL implement FSM states ACCUM, ISSUE, WAIT, RESULT.
REQ-010 ACCUM: osample_ready=1; all other states osample_ready=0.
REQ-011 On accepted sample with isample_bin<36: bin[isample_bin] <= min(bin+isample_mag, 16'hFFFF) (saturating, 17-bit intermediate).
REQ-012 On accepted sample with isample_bin>=36: no bin changes, oerr_bin set to 1.
REQ-013 Accepted sample with isample_last=1 (processed per REQ-011/012 first) SHALL move ACCUM->ISSUE next cycle.
REQ-014 ISSUE: odetect_en=1 for exactly one cycle, then WAIT; odetect_en=0 in every other state.
REQ-015 ohist_bins SHALL be held constant from ISSUE entry until RESULT handshake.
REQ-016 WAIT: cycle counter starts at 0 on entry, increments each cycle; idetect_en=1 captures oresult_orient<=idetect_orient, oresult_peak<=bin[idetect_orient] (0 if idetect_orient>=36), goes RESULT.
REQ-017 WAIT with counter reaching TIMEOUT and no idetect_en: oresult_orient<=6'h3F, oresult_peak<=0, oerr_timeout<=1, go RESULT; idetect_en in same cycle as timeout wins (normal capture).
REQ-018 idetect_en outside WAIT SHALL be ignored.
REQ-019 RESULT: oresult_valid=1, payload stable until iresult_ready=1; on handshake all 36 bins cleared to 0, oresult_valid drops, state ACCUM next cycle.
REQ-020 Nominal detector latency is 7 cycles (idetect_en 7 cycles after odetect_en); controller SHALL accept any latency 1..TIMEOUT.
REQ-021 Sticky flags SHALL clear only on reset.

Reset
REQ-022 On ireset=0 asynchronously: state ACCUM, all bins 0, odetect_en=0, oresult_valid=0, oresult_orient=0, oresult_peak=0, oerr_bin=0, oerr_timeout=0, counter 0; osample_ready=1 after reset release, obusy=0.
REQ-023 Reset mid-WAIT or mid-RESULT SHALL discard the in-flight keypoint; subsequent idetect_en ignored.

Verification
REQ-024 Samples (bin3,100),(bin3,50),(bin10,120,last), detector model latency 7 returning 3 -> odetect_en pulse 1 cycle after last, oresult_valid 8 cycles after pulse, orient=3, peak=150.
REQ-025 Samples (bin5,16'hFFF0),(bin5,16'h0100,last) -> bin5=16'hFFFF, peak=16'hFFFF for orient 5.
REQ-026 Sample bin=40 then (bin0,7,last) -> oerr_bin=1 from acceptance cycle, bins other than bin0 stay 0, bin0=7.
REQ-027 No idetect_en after issue, TIMEOUT=15 -> RESULT after 15 WAIT cycles, orient=6'h3F, peak=0, oerr_timeout=1.
REQ-028 iresult_ready held low 20 cycles -> oresult_valid/payload stable, osample_ready=0 throughout; after handshake all ohist_bins=0 and osample_ready=1 next cycle.
REQ-029 ireset asserted during WAIT, released, then stale idetect_en -> no oresult_valid, state ACCUM, all outputs at reset values.
